// File: rtl/shift_serializer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_serializer_ctrl
//  Description : Sequencer for an external parallel-load, left-shifting
//                register used as a parallel-to-serial converter (MSB first).
//                Accepts one word per ready/valid handshake and streams its
//                bits out over a second ready/valid handshake.
//                Optional macro SHIFT_SER_PARITY_EN appends an even-parity bit
//                after the last data bit of every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_serializer_ctrl #(
    parameter int   width_p = 8,
    parameter logic fill_p  = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               shift_load_o,
    output logic               shift_enable_o,
    output logic               shift_d_o,
    output logic [width_p-1:0] shift_data_o,
    input  logic               shift_msb_i,
    output logic               valid_o,
    output logic               serial_o,
    input  logic               ready_i,
    output logic               word_done_o
);

    localparam int c_cnt_w = $clog2(width_p + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
`ifdef SHIFT_SER_PARITY_EN
    localparam logic [1:0] c_st_parity = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_in_idle;
    logic w_in_shift;
    logic w_in_parity;
    logic w_bit_hs;
    logic w_last_bit_hs;
    logic w_parity_bit;

    assign w_in_idle     = (r_state == c_st_idle);
    assign w_in_shift    = (r_state == c_st_shift);
    assign w_bit_hs      = w_in_shift & ready_i & ~reset_i;
    assign w_last_bit_hs = w_bit_hs & (r_cnt == c_cnt_w'(1));

`ifdef SHIFT_SER_PARITY_EN
    logic r_parity;

    assign w_in_parity  = (r_state == c_st_parity);
    assign w_parity_bit = r_parity;
    // The parity handshake, not the last data bit, closes the word.
    assign word_done_o  = w_in_parity & ready_i & ~reset_i;

    // Running even parity over the data bits actually shifted out.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_parity <= 1'b0;
        end else if (w_in_idle && valid_i) begin
            r_parity <= 1'b0;
        end else if (w_in_shift && ready_i) begin
            r_parity <= r_parity ^ shift_msb_i;
        end
    end
`else
    assign w_in_parity  = 1'b0;
    assign w_parity_bit = 1'b0;
    assign word_done_o  = w_last_bit_hs;
`endif

    // Handshake and register-control outputs; reset forces all of them low.
    assign ready_o        = w_in_idle & ~reset_i;
    assign shift_load_o   = ready_o & valid_i;
    assign shift_enable_o = w_bit_hs;
    assign valid_o        = (w_in_shift | w_in_parity) & ~reset_i;
    assign serial_o       = ~reset_i & (w_in_shift ? shift_msb_i : w_parity_bit);
    assign shift_d_o      = fill_p;
    assign shift_data_o   = data_i;

    // Word sequencing: load in IDLE, count bits down in SHIFT.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (valid_i) begin
                        r_cnt   <= c_cnt_w'(width_p);
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    if (ready_i) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                        if (r_cnt == c_cnt_w'(1)) begin
`ifdef SHIFT_SER_PARITY_EN
                            r_state <= c_st_parity;
`else
                            r_state <= c_st_idle;
`endif
                        end
                    end
                end
`ifdef SHIFT_SER_PARITY_EN
                c_st_parity: begin
                    if (ready_i) begin
                        r_state <= c_st_idle;
                    end
                end
`endif
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
